// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction read at a time and
// hands fetched words plus pre-sliced decode fields to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and id_* stay frozen while stalled.

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP;
            id_pc_q      <= 32'h0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // The slot can take a new word if it is empty or being consumed this cycle.
    assign slot_free = !id_valid_q || id_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        id_valid_d   = id_valid_q && !id_ready;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        imem_req_valid = (state_q == S_REQ) && !redirect_valid;
        imem_req_addr  = pc_q;

        case (state_q)
            S_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (slot_free) begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem_resp_data;
                        id_pc_d    = req_pc_q;
                        state_d    = S_REQ;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_instr_d = imem_resp_data;
                        hold_pc_d    = req_pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    id_valid_d   = 1'b1;
                    id_instr_d   = hold_instr_q;
                    id_pc_d      = hold_pc_q;
                    hold_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A taken branch wins over everything; a still-outstanding read must be
        // swallowed in S_DROP before the new target can be requested.
        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            id_valid_d   = 1'b0;
            id_instr_d   = NOP;
            hold_valid_d = 1'b0;
            if ((state_q == S_WAIT || state_q == S_DROP) && !imem_resp_valid) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:0];
    assign id_funct3 = id_instr_q[14:12];
    assign id_funct7 = id_instr_q[31:25];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder, a stimulus driver, and a
// monitor checking requests and deliveries against an in-order program-stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT under test ----------------
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .dbg_state(dbg_state)
  );

  // ---------------- second instance: PC wrap from top of memory ----------------
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic [31:0] w_nop = NOP;
  logic        w_resp_valid = 1'b0;
  logic        w_id_valid;
  logic [31:0] w_id_instr, w_id_pc;
  logic [6:0]  w_id_opcode, w_id_funct7;
  logic [2:0]  w_id_funct3;
  logic [1:0]  w_dbg_state;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_one),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_nop),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .id_valid(w_id_valid), .id_ready(w_one), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .id_opcode(w_id_opcode), .id_funct3(w_id_funct3), .id_funct7(w_id_funct7),
    .dbg_state(w_dbg_state)
  );

  // ---------------- knobs and bookkeeping ----------------
  int lat_min = 0, lat_max = 0;
  int rdy_pct = 100, idr_pct = 100, redir_pct = 0;
  int errors = 0, checks = 0;
  int deliveries = 0, redirects = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen when none was expected (t=%0t)", name, $time);
  endtask

  // Program image: two known instructions at 0x0/0x4, pseudo-random words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    if (addr == 32'h4) return 32'h00A0_0113;
    return (addr * 32'h2545_F491) ^ 32'h0000_1013;
  endfunction

  // ---------------- driver: decode backpressure, branch redirects, memory ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      id_ready       = ($urandom_range(0, 99) < idr_pct);
      imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      redirect_valid = !rst && ($urandom_range(0, 99) < redir_pct);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'h0000_0040;
        1:       redirect_pc = 32'h0000_0043;
        2:       redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = $urandom();
      endcase
    end
  end

  // ---------------- memory responder: one response per accepted request ----------------
  initial begin
    logic        fire;
    logic [31:0] addr;
    logic        busy;
    int          lat;
    logic [31:0] mdata;
    busy = 1'b0;
    lat = 0;
    mdata = 32'h0;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready && !rst;
      addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (fire) begin
          busy  = 1'b1;
          lat   = $urandom_range(lat_min, lat_max);
          mdata = mem_word(addr);
        end
        if (busy) begin
          if (lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata;
            busy = 1'b0;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // ---------------- wrap instance: zero-wait memory and first two request addresses ----------------
  initial begin
    logic f;
    int   wfires;
    wfires = 0;
    forever begin
      @(negedge clk);
      f = w_req_valid && !rst;
      if (rst) begin
        wfires = 0;
      end else if (f) begin
        if (wfires == 0) chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        else if (wfires == 1) chk("wrap_second_addr", w_req_addr, 32'h0000_0000);
        wfires++;
      end
      @(posedge clk);
      #1;
      w_resp_valid = f;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // Model: requests walk the PC sequentially; each surviving response joins the
  // in-order delivery queue (at most two buffered); a redirect empties the queue,
  // marks any outstanding read as dead and restarts the walk at the target.
  logic [31:0] exp_q[$];
  logic [31:0] mdl_pc = RESET_PC;
  logic [31:0] mdl_out_pc = 32'h0;
  logic        mdl_out = 1'b0;
  logic        mdl_stale = 1'b0;
  logic        after_rst = 1'b1;

  initial begin
    logic [31:0] ep;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mdl_pc    = RESET_PC;
        mdl_out   = 1'b0;
        mdl_stale = 1'b0;
        after_rst = 1'b1;
      end else begin
        if (after_rst) begin
          chk("reset_id_valid", {31'h0, id_valid}, 32'h0);
          chk("reset_id_instr", id_instr, NOP);
          chk("reset_id_pc", id_pc, 32'h0);
          chk("reset_req_addr", imem_req_addr, RESET_PC);
          after_rst = 1'b0;
        end
        chk("req_valid", {31'h0, imem_req_valid},
            {31'h0, (!mdl_out && exp_q.size() < 2 && !redirect_valid)});
        chk("id_valid", {31'h0, id_valid}, {31'h0, (exp_q.size() > 0)});

        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            fail_event("spurious_delivery");
          end else begin
            ep = exp_q.pop_front();
            ei = mem_word(ep);
            chk("id_pc", id_pc, ep);
            chk("id_instr", id_instr, ei);
            chk("id_opcode", {25'h0, id_opcode}, {25'h0, ei[6:0]});
            chk("id_funct3", {29'h0, id_funct3}, {29'h0, ei[14:12]});
            chk("id_funct7", {25'h0, id_funct7}, {25'h0, ei[31:25]});
            deliveries++;
          end
        end

        if (imem_resp_valid) begin
          if (!mdl_out) begin
            fail_event("response_without_request");
          end else begin
            if (!redirect_valid && !mdl_stale) exp_q.push_back(mdl_out_pc);
            mdl_out = 1'b0;
          end
        end

        if (redirect_valid) begin
          exp_q.delete();
          mdl_stale = mdl_out;
          mdl_pc    = {redirect_pc[31:2], 2'b00};
          redirects++;
        end

        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, mdl_pc);
          mdl_out    = 1'b1;
          mdl_stale  = 1'b0;
          mdl_out_pc = mdl_pc;
          mdl_pc     = mdl_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- phases ----------------
  task automatic run(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int idr,
                           input int rdr);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; idr_pct = idr; redir_pct = rdr;
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    // Zero-wait memory, decode always ready.
    set_knobs(0, 0, 100, 100, 0);
    run(12);
    // Decode stalls: slot holds, second word parks in the hold buffer.
    set_knobs(0, 0, 100, 0, 0);
    run(6);
    set_knobs(0, 0, 100, 100, 0);
    run(6);
    // Memory refuses requests for three cycles.
    set_knobs(0, 0, 0, 100, 0);
    run(3);
    set_knobs(0, 0, 100, 100, 0);
    run(6);
    // Slow responses with frequent redirects, catching waits and drops.
    set_knobs(2, 2, 100, 80, 25);
    run(300);
    // Fully random traffic.
    set_knobs(0, 3, 70, 60, 6);
    run(3000);
    // Reset in the middle of traffic, then more random traffic.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    set_knobs(0, 3, 70, 60, 6);
    run(1500);
    set_knobs(0, 0, 100, 100, 0);
    run(20);
    chk("progress", {31'h0, (deliveries >= 200)}, 32'h1);
    chk("redirects_seen", {31'h0, (redirects >= 20)}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
